// File: rtl/count_pkg.sv
// count_pkg: shared state encoding and default widths for the count pulse
// emitter and its receiver model.
package count_pkg;

    localparam int unsigned LEN_W   = 16;
    localparam int unsigned GAP_W   = 8;
    localparam int unsigned CNT_W   = 64;
    localparam int unsigned PHASE_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/count_model.sv
// count_model: cycle-exact model of the dual event counter that consumes the
// Slt/En stream. Channel 0 counts every enable; channel 1 counts every fourth
// enable through a 2-bit phase. Phase and counts persist until Reset.
module count_model #(
    parameter int unsigned CNT_W = count_pkg::CNT_W
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Slt,
    output logic [CNT_W-1:0] Exp0,
    output logic [CNT_W-1:0] Exp1
);
    import count_pkg::*;

    logic [PHASE_W-1:0] phase;

    // Count each enable on the selected channel; channel 1 advances the phase
    // and counts when the phase rolls over to zero.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Exp0  <= '0;
            Exp1  <= '0;
            phase <= '0;
        end else if (En) begin
            if (!Slt) begin
                Exp0 <= Exp0 + CNT_W'(1);
            end else begin
                phase <= phase + PHASE_W'(1);
                if (phase == '1) begin
                    Exp1 <= Exp1 + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/count_pulse_emitter.sv
// count_pulse_emitter: transmitter side of the Slt/En event interface.
// Accepts a job (channel, pulse count, gap) on Start and emits exactly Len
// one-cycle enable pulses, then strobes Done. Also carries a model of the
// receiving counter (count_model) driven from the emitted stream.
// Build option: COUNT_EMIT_GAP_EN enables the inter-pulse gap; without it the
// Gap input is ignored and pulses are always back-to-back.
module count_pulse_emitter #(
    parameter int unsigned LEN_W = count_pkg::LEN_W,
    parameter int unsigned GAP_W = count_pkg::GAP_W,
    parameter int unsigned CNT_W = count_pkg::CNT_W
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Chan,
    input  logic [LEN_W-1:0] Len,
    input  logic [GAP_W-1:0] Gap,
    input  logic             Abort,
    output logic             En,
    output logic             Slt,
    output logic             Busy,
    output logic             Done,
    output logic [LEN_W-1:0] Sent,
    output logic [CNT_W-1:0] Exp0,
    output logic [CNT_W-1:0] Exp1
);
    import count_pkg::*;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             chan_q;
    logic [LEN_W-1:0] rem_q;
    logic [LEN_W-1:0] sent_q;
    logic             en_q;
    logic             slt_q;
    logic             busy_q;
    logic             done_q;
`ifdef COUNT_EMIT_GAP_EN
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_cnt;
`else
    logic             gap_unused;
    assign gap_unused = ^Gap;
`endif

    assign accept = (state == IDLE) && Start && !Abort;

    // Next-state selection for the job sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (Len == '0) ? DONE : EMIT;
                end
            end
            EMIT: begin
                if (Abort) begin
                    state_nxt = IDLE;
                end else if (rem_q == LEN_W'(1)) begin
                    state_nxt = DONE;
`ifdef COUNT_EMIT_GAP_EN
                end else if (gap_q != '0) begin
                    state_nxt = GAP;
`endif
                end else begin
                    state_nxt = EMIT;
                end
            end
`ifdef COUNT_EMIT_GAP_EN
            GAP: begin
                if (Abort) begin
                    state_nxt = IDLE;
                end else if (gap_cnt == '0) begin
                    state_nxt = EMIT;
                end
            end
`endif
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the job channel and count down remaining pulses.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            chan_q <= 1'b0;
            rem_q  <= '0;
        end else if (accept) begin
            chan_q <= Chan;
            rem_q  <= Len;
        end else if (state == EMIT) begin
            rem_q <= rem_q - LEN_W'(1);
        end
    end

`ifdef COUNT_EMIT_GAP_EN
    // Latch the gap and time the idle cycles between pulses.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            gap_q   <= '0;
            gap_cnt <= '0;
        end else begin
            if (accept) begin
                gap_q <= Gap;
            end
            if (state == EMIT) begin
                gap_cnt <= gap_q - GAP_W'(1);
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
        end
    end
`endif

    // Count pulses at the edge that ends each En cycle, so an aborted job
    // still reports every pulse the receiver actually saw.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sent_q <= '0;
        end else if (accept) begin
            sent_q <= '0;
        end else if (en_q) begin
            sent_q <= sent_q + LEN_W'(1);
        end
    end

    // Registered interface outputs, derived from the state being entered.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            en_q   <= 1'b0;
            slt_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            en_q   <= (state_nxt == EMIT);
            busy_q <= (state_nxt != IDLE);
            done_q <= (state_nxt == DONE);
            if (state_nxt == IDLE) begin
                slt_q <= 1'b0;
            end else if (accept) begin
                slt_q <= Chan;
            end else begin
                slt_q <= chan_q;
            end
        end
    end

    count_model #(
        .CNT_W (CNT_W)
    ) u_model (
        .Clk   (Clk),
        .Reset (Reset),
        .En    (en_q),
        .Slt   (slt_q),
        .Exp0  (Exp0),
        .Exp1  (Exp1)
    );

    assign En   = en_q;
    assign Slt  = slt_q;
    assign Busy = busy_q;
    assign Done = done_q;
    assign Sent = sent_q;

endmodule

// File: tb/tb_count_pulse_emitter.sv
// tb_count_pulse_emitter: table of jobs with expected results queued at
// issue and checked when Done appears, plus hand-written abort, busy-start,
// mid-job reset and counter-wrap sequences.
module tb_count_pulse_emitter;

    localparam int unsigned LEN_W = 16;
    localparam int unsigned GAP_W = 8;
    localparam int unsigned CNT_W = 64;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             Start;
    logic             Chan;
    logic [LEN_W-1:0] Len;
    logic [GAP_W-1:0] Gap;
    logic             Abort;
    logic             En;
    logic             Slt;
    logic             Busy;
    logic             Done;
    logic [LEN_W-1:0] Sent;
    logic [CNT_W-1:0] Exp0;
    logic [CNT_W-1:0] Exp1;

    logic       sm_en;
    logic       sm_slt;
    logic [3:0] sm_exp0;
    logic [3:0] sm_exp1;

    int tests = 0;
    int fails = 0;

    count_pulse_emitter #(
        .LEN_W (LEN_W),
        .GAP_W (GAP_W),
        .CNT_W (CNT_W)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .Chan  (Chan),
        .Len   (Len),
        .Gap   (Gap),
        .Abort (Abort),
        .En    (En),
        .Slt   (Slt),
        .Busy  (Busy),
        .Done  (Done),
        .Sent  (Sent),
        .Exp0  (Exp0),
        .Exp1  (Exp1)
    );

    // Narrow model instance so counter wrap-around is reachable in a few cycles.
    count_model #(
        .CNT_W (4)
    ) u_small (
        .Clk   (Clk),
        .Reset (Reset),
        .En    (sm_en),
        .Slt   (sm_slt),
        .Exp0  (sm_exp0),
        .Exp1  (sm_exp1)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic            chan;
        int unsigned     len;
        int unsigned     gap;
        int unsigned     sent;
        longint unsigned exp0;
        longint unsigned exp1;
    } job_t;

    typedef struct {
        int unsigned     latency;
        int unsigned     pulses;
        int unsigned     spacing;
        int unsigned     sent;
        longint unsigned exp0;
        longint unsigned exp1;
    } expect_t;

    job_t    jobs[7];
    expect_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    function automatic int unsigned gap_eff(input int unsigned g);
`ifdef COUNT_EMIT_GAP_EN
        return g;
`else
        return 0;
`endif
    endfunction

    task automatic run_job(input job_t j, input int idx);
        expect_t     e;
        expect_t     got;
        int unsigned c;
        int unsigned npulse;
        int unsigned first;
        int unsigned last;
        int unsigned done_at;
        int unsigned bad_spacing;
        int unsigned bad_slt;
        logic        slt_at_done;
        logic        busy_at_done;
        string       tag;

        e.latency = (j.len == 0) ? 1 : j.len + (j.len - 1) * gap_eff(j.gap) + 1;
        e.pulses  = j.len;
        e.spacing = gap_eff(j.gap) + 1;
        e.sent    = j.sent;
        e.exp0    = j.exp0;
        e.exp1    = j.exp1;
        sb.push_back(e);

        Chan  = j.chan;
        Len   = LEN_W'(j.len);
        Gap   = GAP_W'(j.gap);
        Start = 1'b1;
        next_cycle();
        Start = 1'b0;

        c = 1; npulse = 0; first = 0; last = 0; done_at = 0;
        bad_spacing = 0; bad_slt = 0; slt_at_done = 1'b0; busy_at_done = 1'b0;
        while (done_at == 0 && c <= 400) begin
            if (En === 1'b1) begin
                if (npulse == 0) first = c;
                else if (c - last != e.spacing) bad_spacing++;
                if (Slt !== j.chan) bad_slt++;
                npulse++;
                last = c;
            end
            if (Done === 1'b1) begin
                done_at      = c;
                slt_at_done  = Slt;
                busy_at_done = Busy;
            end else begin
                next_cycle();
                c++;
            end
        end

        got = sb.pop_front();
        tag = $sformatf("job%0d", idx);
        check({tag, "_done_latency"}, 64'(done_at), 64'(got.latency));
        check({tag, "_pulse_count"}, 64'(npulse), 64'(got.pulses));
        check({tag, "_bad_spacing"}, 64'(bad_spacing), 64'd0);
        check({tag, "_bad_slt"}, 64'(bad_slt), 64'd0);
        check({tag, "_sent"}, 64'(Sent), 64'(got.sent));
        check({tag, "_exp0"}, Exp0, got.exp0);
        check({tag, "_exp1"}, Exp1, got.exp1);
        check({tag, "_busy_at_done"}, 64'(busy_at_done), 64'd1);
        if (j.len != 0) begin
            check({tag, "_first_pulse"}, 64'(first), 64'd1);
            check({tag, "_slt_at_done"}, 64'(slt_at_done), 64'(j.chan));
        end

        next_cycle();
        check({tag, "_done_one_cycle"}, 64'(Done), 64'd0);
        check({tag, "_idle_busy"}, 64'(Busy), 64'd0);
        check({tag, "_idle_slt"}, 64'(Slt), 64'd0);
        check({tag, "_idle_en"}, 64'(En), 64'd0);
    endtask

    initial begin
        int unsigned c;
        int unsigned npulse;
        int unsigned seen;
        logic        found;

        jobs[0] = '{1'b0, 5, 0,   5, 5, 0};
        jobs[1] = '{1'b1, 9, 2,   9, 5, 2};
        jobs[2] = '{1'b1, 3, 1,   3, 5, 3};
        jobs[3] = '{1'b0, 0, 3,   0, 5, 3};
        jobs[4] = '{1'b0, 1, 5,   1, 6, 3};
        jobs[5] = '{1'b1, 4, 7,   4, 6, 4};
        jobs[6] = '{1'b0, 2, 255, 2, 8, 4};

        Reset = 1'b1; Start = 1'b0; Chan = 1'b0; Len = '0; Gap = '0; Abort = 1'b0;
        sm_en = 1'b0; sm_slt = 1'b0;
        #1;
        check("reset_en",   64'(En),   64'd0);
        check("reset_busy", 64'(Busy), 64'd0);
        check("reset_done", 64'(Done), 64'd0);
        check("reset_slt",  64'(Slt),  64'd0);
        check("reset_sent", 64'(Sent), 64'd0);
        check("reset_exp0", Exp0, 64'd0);
        check("reset_exp1", Exp1, 64'd0);
        repeat (3) @(posedge Clk);
        #3 Reset = 1'b0;
        next_cycle();
        check("post_reset_busy", 64'(Busy), 64'd0);

        for (int i = 0; i < 7; i++) begin
            run_job(jobs[i], i);
        end

        // Start together with Abort in IDLE is ignored.
        Chan = 1'b0; Len = 16'd4; Gap = '0; Start = 1'b1; Abort = 1'b1;
        next_cycle();
        Start = 1'b0; Abort = 1'b0;
        check("start_abort_busy", 64'(Busy), 64'd0);
        check("start_abort_en",   64'(En),   64'd0);

        // Abort after the third pulse, with Start held high while busy.
        Chan = 1'b0; Len = 16'd10; Gap = 8'd1; Start = 1'b1;
        next_cycle();
        Len = 16'd2;
        c = 1; npulse = 0; found = 1'b0;
        while (!found && c <= 40) begin
            if (c == 2) Start = 1'b0;
            if (En === 1'b1) npulse++;
            if (npulse == 3) begin
                Abort = 1'b1;
                found = 1'b1;
            end
            next_cycle();
            c++;
        end
        Abort = 1'b0;
        Start = 1'b0;
        check("abort_reached_3rd", 64'(found), 64'd1);
        check("abort_busy", 64'(Busy), 64'd0);
        check("abort_en",   64'(En),   64'd0);
        check("abort_done", 64'(Done), 64'd0);
        check("abort_sent", 64'(Sent), 64'd3);
        check("abort_exp0", Exp0, 64'd11);
        check("abort_exp1", Exp1, 64'd4);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            if (Done === 1'b1 || En === 1'b1) seen++;
        end
        check("abort_no_activity", 64'(seen), 64'd0);

        // Asynchronous reset in the middle of a job.
        Chan = 1'b1; Len = 16'd4; Gap = 8'd3; Start = 1'b1;
        next_cycle();
        Start = 1'b0;
        check("midjob_first_pulse", 64'(En), 64'd1);
        next_cycle();
        #2 Reset = 1'b1;
        #1;
        check("midreset_en",   64'(En),   64'd0);
        check("midreset_busy", 64'(Busy), 64'd0);
        check("midreset_done", 64'(Done), 64'd0);
        check("midreset_slt",  64'(Slt),  64'd0);
        check("midreset_sent", 64'(Sent), 64'd0);
        check("midreset_exp0", Exp0, 64'd0);
        check("midreset_exp1", Exp1, 64'd0);
        #2 Reset = 1'b0;
        next_cycle();
        check("after_midreset_busy", 64'(Busy), 64'd0);

        // Counter wrap on the narrow model instance.
        sm_slt = 1'b0; sm_en = 1'b1;
        repeat (15) next_cycle();
        check("wrap_exp0_max", 64'(sm_exp0), 64'd15);
        next_cycle();
        check("wrap_exp0_zero", 64'(sm_exp0), 64'd0);
        next_cycle();
        check("wrap_exp0_one", 64'(sm_exp0), 64'd1);
        sm_en = 1'b0;
        next_cycle();
        sm_slt = 1'b1; sm_en = 1'b1;
        repeat (60) next_cycle();
        check("wrap_exp1_max", 64'(sm_exp1), 64'd15);
        repeat (4) next_cycle();
        check("wrap_exp1_zero", 64'(sm_exp1), 64'd0);
        repeat (4) next_cycle();
        check("wrap_exp1_one", 64'(sm_exp1), 64'd1);
        check("wrap_exp0_hold", 64'(sm_exp0), 64'd1);
        sm_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
